ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
Multi-cycle divide controller for the EX stage, covering RV32M DIV/DIVU/REM/REMU. It accepts a divide request from the EX stage and stalls the pipeline while it runs. It sequences an iterative restoring divider and returns the quotient or remainder to the EX/MEM result mux together with a one-cycle done strobe. It honours bus stalls and pipeline flushes.

Parameters:
XLEN, 32, operand/result width
STEP_BITS, 1, quotient bits resolved per cycle; legal values 1 or 2; ITER = XLEN/STEP_BITS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  kill instruction in EX (branch taken / jump)
hold  in  1  bus stall on the MEM side (busStall[1]); freezes the done handshake
div_req  in  1  EX holds a divide instruction; stays high until the instruction leaves EX
div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
src1  in  XLEN  dividend (already forwarded)
src2  in  XLEN  divisor (already forwarded)
div_stall  out  1  freeze IF/ID/EX; combinational
div_done  out  1  result valid this cycle
div_result  out  XLEN  quotient or remainder; registered
div_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, FIX, DONE. Reset and flush force IDLE from any state. Reset clears the counter, div_result and all internal registers to 0.
- Reset values: div_stall=0, div_done=0, div_result=0, div_busy=0.
- div_stall = div_req & (state != DONE) & ~flush.
- IDLE, div_req & ~flush:
  - Divisor == 0: div_result = 0xFFFFFFFF for DIV/DIVU, src1 for REM/REMU; go to DONE.
  - Signed overflow (DIV/REM, src1 = 0x80000000, src2 = 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0; go to DONE.
  - Otherwise latch |src1|, |src2| (absolute value only for signed ops), quotient sign = s1^s2, remainder sign = s1, op; counter = ITER-1; go to RUN.
- RUN: each cycle performs STEP_BITS restoring shift-subtract steps on the {rem, quo} register pair. At counter == 0 go to FIX; otherwise decrement the counter.
- FIX: apply two's-complement sign correction. Select quotient (DIV/DIVU) or remainder (REM/REMU) into div_result. Go to DONE.
- DONE: div_done=1 and div_stall=0.
  - hold=1: stay in DONE with div_result stable.
  - hold=0: go to IDLE.
  - div_req seen in DONE belongs to the same instruction and is ignored.
- Latency with STEP_BITS=1, request seen in cycle 0: RUN occupies cycles 1..32, FIX cycle 33, DONE cycle 34. div_stall is high in cycles 0..33. STEP_BITS=2: DONE in cycle 18.
- Special-case latency: DONE in cycle 1; div_stall high in cycle 0 only.
- Back-to-back divides: the second request is seen in IDLE the cycle after DONE exits and restarts normally.
- div_req dropping in RUN/FIX (not via flush) is a protocol error. Assertion in simulation; the hardware continues.
- Operand latching: operands are sampled only in IDLE. Forwarding changes during RUN have no effect.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, when |src1| < |src2| (non-special case), skip RUN. Go directly to FIX with quo=0 and rem=|src1|; DONE in cycle 2.
- Undefined: every non-special divide takes the full ITER cycles.

Decomposition:
- Package ex_div_pkg holds:
  - div_op_e enum (DIV, DIVU, REM, REMU)
  - div_state_e enum (IDLE, RUN, FIX, DONE)
  - constant DIV_OVF_DIVIDEND = 32'h8000_0000
  - function abs_if_signed
- Sub-module div_step (combinational): one restoring step {rem, quo, divisor} -> {rem', quo'}. Instantiated STEP_BITS times in a chain inside ex_div_ctrl.

Test Plan:
- DIVU 100/7: div_result=14, div_done in cycle 34, div_stall high cycles 0..33; REMU 100/7 gives 2.
- DIV -100/7: 0xFFFFFFF2 (-14); REM -100/7: 0xFFFFFFFE (-2); DIV 100/-7: -14.
- DIV 5/0: 0xFFFFFFFF in cycle 1; REM 5/0: 5; DIV 0x80000000/-1: 0x80000000; REM of the same operands: 0.
- DIVU 1000/10 with flush asserted in cycle 10: state IDLE in cycle 11, div_stall=0, no div_done; a following DIVU 9/3 gives 3 at its normal latency.
- hold=1 for 3 cycles on reaching DONE: div_done and div_result stay stable for 4 cycles, then IDLE. rst pulsed mid-RUN clears all outputs to 0 asynchronously.
- DIV_EARLY_OUT_EN: DIVU 3/10 gives quotient 0 in cycle 2 and REMU 3/10 gives 3; with the macro undefined, both complete in cycle 34.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared types and helpers for the EX-stage divide controller.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  // Magnitude of v when it is a signed operand, v unchanged otherwise.
  function automatic logic [31:0] abs_if_signed(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {rem, quo} register pair.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign ge      = shifted >= {1'b0, dvs_i};
  // rem < divisor on entry, so a successful subtract always fits in XLEN bits
  assign diff    = shifted[XLEN-1:0] - dvs_i;
  assign rem_o   = ge ? diff : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ge};
endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle RV32M divide controller for EX (DIV/DIVU/REM/REMU).
// Optional DIV_EARLY_OUT_EN: skip iteration when |src1| < |src2|.
module ex_div_ctrl
  import ex_div_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            hold,
  input  logic            div_req,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            div_stall,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);
  localparam int ITER = XLEN / STEP_BITS;
  localparam int CW   = $clog2(ITER);

  div_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            q_neg, r_neg;
  div_op_e         op_q;

  logic            sgn_op, is_rem_in, div_by_zero, ovf, early_out;
  logic [XLEN-1:0] abs1, abs2, quo_fix, rem_fix;

  assign sgn_op      = ~div_op[0];
  assign is_rem_in   = div_op[1];
  assign abs1        = abs_if_signed(src1, sgn_op);
  assign abs2        = abs_if_signed(src2, sgn_op);
  assign div_by_zero = (src2 == '0);
  assign ovf         = sgn_op && (src1 == DIV_OVF_DIVIDEND) && (src2 == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = abs1 < abs2;
`else
  assign early_out = 1'b0;
`endif

  logic [STEP_BITS:0][XLEN-1:0] rem_ch, quo_ch;
  assign rem_ch[0] = rem_q;
  assign quo_ch[0] = quo_q;

  for (genvar i = 0; i < STEP_BITS; i++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_ch[i]),
      .quo_i (quo_ch[i]),
      .dvs_i (dvs_q),
      .rem_o (rem_ch[i+1]),
      .quo_o (quo_ch[i+1])
    );
  end

  assign quo_fix = q_neg ? XLEN'(-quo_q) : quo_q;
  assign rem_fix = r_neg ? XLEN'(-rem_q) : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      op_q       <= DIV;
      div_result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (div_req) begin
          if (div_by_zero) begin
            div_result <= is_rem_in ? src1 : '1;
            state      <= DONE;
          end else if (ovf) begin
            div_result <= is_rem_in ? '0 : src1;
            state      <= DONE;
          end else begin
            dvs_q <= abs2;
            q_neg <= sgn_op & (src1[XLEN-1] ^ src2[XLEN-1]);
            r_neg <= sgn_op & src1[XLEN-1];
            op_q  <= div_op_e'(div_op);
            cnt   <= CW'(ITER - 1);
            if (early_out) begin
              rem_q <= abs1;
              quo_q <= '0;
              state <= FIX;
            end else begin
              rem_q <= '0;
              quo_q <= abs1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_ch[STEP_BITS];
          quo_q <= quo_ch[STEP_BITS];
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          div_result <= (op_q == REM || op_q == REMU) ? rem_fix : quo_fix;
          state      <= DONE;
        end
        DONE: if (!hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A request in DONE belongs to the retiring instruction, so it never stalls.
  assign div_stall = div_req & (state != DONE) & ~flush & ~rst;
  assign div_done  = (state == DONE);
  assign div_busy  = (state != IDLE);

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == RUN || state == FIX) |-> (div_req || flush));

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: driver pushes expectations, monitor checks on div_done.
module tb_ex_div_ctrl;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, hold = 1'b0, div_req = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] src1 = '0, src2 = '0;
  logic        div_stall, div_done, div_busy;
  logic [31:0] div_result;

  ex_div_ctrl #(.XLEN(32), .STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .div_req(div_req),
    .div_op(div_op), .src1(src1), .src2(src2), .div_stall(div_stall),
    .div_done(div_done), .div_result(div_result), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif
  localparam int LAT = 34;

  typedef struct { logic [31:0] res; int cyc; } sb_t;
  sb_t sb[$];
  sb_t e;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (div_done && !prev_done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h, expected no completion", div_result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", div_result, e.res);
        chk("sb_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_done <= div_done;
  end

  task automatic run_div(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input int hold_n);
    int n;
    bit ok;
    @(negedge clk);
    div_req = 1'b1; div_op = op; src1 = a; src2 = b;
    sb.push_back('{exp, cyc + lat});
    ok = 1'b1;
    for (int k = 0; k < lat; k++) begin
      #1;
      if (!div_stall || div_done) ok = 1'b0;
      // Forwarding noise once the operands should already be latched.
      if (k == 1) begin src1 = ~a; src2 = b ^ 32'h5; end
      @(negedge clk);
    end
    chk({nm, "_stall_seq"}, {31'b0, ok}, 32'd1);
    n = 0;
    while (!div_done && n < 60) begin @(negedge clk); n++; end
    if (!div_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no div_done, expected div_done within budget", nm);
      div_req = 1'b0;
      return;
    end
    #1;
    chk({nm, "_stall_in_done"}, {31'b0, div_stall}, 32'd0);
    for (int h = 0; h < hold_n; h++) begin
      hold = 1'b1;
      @(negedge clk); #1;
      chk({nm, "_hold_done"}, {31'b0, div_done}, 32'd1);
      chk({nm, "_hold_result"}, div_result, exp);
    end
    hold = 1'b0; div_req = 1'b0;
    @(negedge clk); #1;
    chk({nm, "_idle_busy"}, {31'b0, div_busy}, 32'd0);
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_result", div_result, 32'h0);
    chk("rst_done",   {31'b0, div_done},  32'd0);
    chk("rst_busy",   {31'b0, div_busy},  32'd0);
    chk("rst_stall",  {31'b0, div_stall}, 32'd0);
    rst = 1'b0;

    run_div("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14, LAT, 0);
    run_div("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2,  LAT, 0);
    run_div("div_m100_7",  DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT, 0);
    run_div("rem_m100_7",  REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT, 0);
    run_div("div_100_m7",  DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT, 0);
    run_div("rem_100_m7",  REM,  32'd100, 32'hFFFF_FFF9, 32'd2, LAT, 0);
    run_div("div_5_0",     DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("rem_5_0",     REM,  32'd5, 32'd0, 32'd5, 1, 0);
    run_div("divu_5_0",    DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_div("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    run_div("divu_big",    DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, EO_LAT, 0);
    run_div("remu_big",    REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO_LAT, 0);
    run_div("divu_max_1",  DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT, 0);
    run_div("divu_3_10",   DIVU, 32'd3, 32'd10, 32'd0, EO_LAT, 0);
    run_div("remu_3_10",   REMU, 32'd3, 32'd10, 32'd3, EO_LAT, 0);
    run_div("divu_hold",   DIVU, 32'd100, 32'd7, 32'd14, LAT, 3);

    // Flush in cycle 10 of a running divide.
    @(negedge clk);
    div_req = 1'b1; div_op = DIVU; src1 = 32'd1000; src2 = 32'd10;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_pre_busy", {31'b0, div_busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk); #1;
    chk("flush_busy",  {31'b0, div_busy},  32'd0);
    chk("flush_stall", {31'b0, div_stall}, 32'd0);
    chk("flush_done",  {31'b0, div_done},  32'd0);
    flush = 1'b0; div_req = 1'b0;
    repeat (3) @(negedge clk);
    run_div("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, LAT, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    div_req = 1'b1; div_op = DIVU; src1 = 32'd100; src2 = 32'd7;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_result", div_result, 32'h0);
    chk("arst_busy",   {31'b0, div_busy},  32'd0);
    chk("arst_done",   {31'b0, div_done},  32'd0);
    chk("arst_stall",  {31'b0, div_stall}, 32'd0);
    div_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
